ff_register_file_nr_1w_be: RTL
==============================

# ff_register_file_nr_1w_be

Flip-flop register file with `N_READ` independent registered read ports, one byte-enabled write port, optional write-to-read bypass and a sequential hardware clear engine. It replaces the single-read-port FF register file wherever a cluster needs several readers, such as accelerator operand fetch or multi-lane streamers. It also covers blocks that must wipe state without a full reset. Storage is FF-based and not bulk-reset, which saves reset fan-out; the clear engine provides deterministic contents instead.

## Interface
- `ADDR_WIDTH`, 5: address bits; depth `N_WORDS = 2**ADDR_WIDTH`.
- `DATA_WIDTH`, 64: word width; must be a multiple of 8.
- `N_READ`, 2: number of read ports, ≥1.
- `BYPASS`, 1: 1 = a same-cycle write to the read address is forwarded (write-first); 0 = the read returns old contents (read-first).
- `CLEAR_ON_RESET`, 1: 1 = the clear engine runs automatically after reset.

Reset and clock (already decided): one clock `clk`; reset `rst_n`, synchronous, active-low.

- `clk` input 1: clock.
- `rst_n` input 1: synchronous active-low reset.
- `ClearReq` input 1: pulse to start a full clear.
- `Busy` output 1: clear in progress.
- `ReadEnable` input `[N_READ]`: per-port read strobe.
- `ReadAddr` input `[N_READ][ADDR_WIDTH]`: per-port read address.
- `ReadData` output `[N_READ][DATA_WIDTH]`: registered read data.
- `WriteEnable` input 1: write strobe.
- `WriteAddr` input `ADDR_WIDTH`: write address.
- `WriteBe` input `DATA_WIDTH/8`: byte enables.
- `WriteData` input `DATA_WIDTH`: write data.

## Operation
- **Write.** When `WriteEnable`=1 and `Busy`=0, byte `b` of `mem[WriteAddr]` is updated if `WriteBe[b]`=1. Bytes with `WriteBe[b]`=0 keep their value. `WriteBe`=0 is a legal no-op.
- **Read.** Each port `p` is independent. When `ReadEnable[p]`=1, the port register loads `mem[ReadAddr[p]]`. When `ReadEnable[p]`=0, `ReadData[p]` holds its value. Multiple ports may read the same address.
- **Bypass.**
  - With `BYPASS`=1, a read of `WriteAddr` during an accepted write returns the byte-merged new word.
  - With `BYPASS`=0, it returns the pre-write word.
- **Clear FSM.** States are `IDLE` and `CLEAR`, with counter `clr_idx` of width `ADDR_WIDTH`.
  - In `IDLE`, `ClearReq`=1 moves to `CLEAR` with `clr_idx`=0.
  - In `CLEAR`, each cycle writes 0 to `mem[clr_idx]` and increments `clr_idx`. When `clr_idx`=`N_WORDS-1` is written, the FSM returns to `IDLE`.
  - `Busy` = (state==`CLEAR`).
- **During `Busy`.**
  - User writes are dropped (no queuing).
  - An enabled read loads 0 into its port register.
  - `ClearReq` is ignored and does not restart the clear.
- **Simultaneous events.** `ClearReq` together with `WriteEnable` in `IDLE` performs the write that cycle; the following clear then erases it.
- **Reset.**
  - All `ReadData` are 0 and `clr_idx`=0.
  - The state is `CLEAR` if `CLEAR_ON_RESET`=1, otherwise `IDLE`, so `Busy` resets to `CLEAR_ON_RESET`.
  - Reset asserted mid-clear restarts from index 0 when `CLEAR_ON_RESET`=1, or aborts (contents partially cleared) when it is 0.
  - Array contents are unaffected by reset itself.

## Timing
- Read latency is 1 cycle: address at edge n gives data after edge n+1. Ports are fully pipelined.
- A write at edge n is visible to a read issued at edge n+1 regardless of `BYPASS`. `BYPASS` only matters for a read at edge n.
- A clear lasts exactly `N_WORDS` cycles. With `ClearReq` sampled at edge n, `Busy`=1 from edge n+1 through edge n+`N_WORDS`, and the first accepted write is at edge n+`N_WORDS`+1.
- After reset deassertion with `CLEAR_ON_RESET`=1, `Busy` is high for `N_WORDS` cycles.
- No combinational path from any input to `ReadData` or `Busy`.

## Structure
- Package `scm_rf_pkg`:
  - enum `rf_clr_state_e {IDLE, CLEAR}`.
  - Function `be_merge(old, new, be)`, used by both the write path and the bypass path.
- Sub-module `ff_rf_read_port`: one registered read port, covering mux, bypass compare and zero-during-busy. Instantiated `N_READ` times via generate.
- Elaboration assertions: `DATA_WIDTH % 8 == 0` and `N_READ >= 1`.

## Test plan
1. Reset with `CLEAR_ON_RESET`=1, `ADDR_WIDTH`=3 -> `Busy`=1 for 8 cycles, then 0; all 8 addresses read 0; `ReadData` is 0 during reset.
2. Write 0x1122334455667788 to addr 5 with `WriteBe`=0xFF, then write 0xAAAA…AA with `WriteBe`=0x0F -> port 1 read of addr 5 returns 0x11223344AAAAAAAA one cycle later.
3. Same-cycle write 0xDEAD to addr 3 and read addr 3 on port 0 -> `BYPASS`=1 returns 0xDEAD; `BYPASS`=0 returns the prior value.
4. Ports 0 and 1 read addrs 2 and 7 on consecutive cycles with `ReadEnable` toggling -> correct data at 1-cycle latency; `ReadData` holds when its enable is low.
5. `ClearReq` together with a write to addr 1, then writes during `Busy` and a second `ClearReq` mid-clear -> `Busy` lasts exactly `N_WORDS` cycles; all entries read 0 afterwards; dropped writes leave no effect.
6. `rst_n` low for one cycle midway through a clear with `CLEAR_ON_RESET`=1 -> the clear restarts at index 0 and takes the full `N_WORDS` cycles.

Source files
------------

// File: rtl/scm_rf_pkg.sv
// Shared types and helpers for the flip-flop register file family.
// be_merge is used by the write path and by each read port's bypass path, so
// a forwarded word always matches what the array will hold one cycle later.
package scm_rf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_clr_state_e;

  // Widest word be_merge can handle; callers widen/narrow with casts.
  localparam int unsigned RF_MAX_DW = 512;
  localparam int unsigned RF_MAX_BE = RF_MAX_DW / 8;

  // Replace byte b of old_word with byte b of new_word wherever be[b] is set.
  function automatic logic [RF_MAX_DW-1:0] be_merge(
    input logic [RF_MAX_DW-1:0] old_word,
    input logic [RF_MAX_DW-1:0] new_word,
    input logic [RF_MAX_BE-1:0] be
  );
    logic [RF_MAX_DW-1:0] res;
    res = old_word;
    for (int b = 0; b < int'(RF_MAX_BE); b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ff_rf_read_port.sv
// One registered read port of the FF register file.
// Selects the addressed word, optionally forwards a same-cycle write
// (byte-merged), and returns zero while the clear engine is running.
module ff_rf_read_port
  import scm_rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned N_WORDS    = 2 ** ADDR_WIDTH,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 busy_i,
  input  logic                                 rd_en_i,
  input  logic [ADDR_WIDTH-1:0]                rd_addr_i,
  input  logic [N_WORDS-1:0][DATA_WIDTH-1:0]   mem_i,
  input  logic                                 wr_en_i,
  input  logic [ADDR_WIDTH-1:0]                wr_addr_i,
  input  logic [DATA_WIDTH/8-1:0]              wr_be_i,
  input  logic [DATA_WIDTH-1:0]                wr_data_i,
  output logic [DATA_WIDTH-1:0]                rd_data_o
);

  logic [DATA_WIDTH-1:0] stored_word;
  logic [DATA_WIDTH-1:0] fwd_word;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Next port value: hold when disabled, zero while clearing, else array or forwarded word.
  always_comb begin
    stored_word = mem_i[rd_addr_i];
    fwd_word    = DATA_WIDTH'(be_merge(RF_MAX_DW'(stored_word),
                                       RF_MAX_DW'(wr_data_i),
                                       RF_MAX_BE'(wr_be_i)));
    // wr_en_i is already qualified with "not busy" by the top level.
    fwd_hit     = BYPASS && wr_en_i && (wr_addr_i == rd_addr_i);
    rd_data_d   = rd_data_q;
    if (rd_en_i) begin
      if (busy_i) begin
        rd_data_d = '0;
      end else if (fwd_hit) begin
        rd_data_d = fwd_word;
      end else begin
        rd_data_d = stored_word;
      end
    end
  end

  // Port output register; cleared by reset so readers never see stale data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ff_register_file_nr_1w_be.sv
// Flip-flop register file: N_READ registered read ports, one byte-enabled
// write port, and a sequential clear engine. The array itself is not reset;
// the clear engine (optionally started by reset) gives it known contents.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | normal operation, user writes accepted, ClearReq starts a clear
//   CLEAR | one word zeroed per cycle at clr_idx; user writes dropped,
//         | enabled reads return 0, ClearReq ignored
module ff_register_file_nr_1w_be
  import scm_rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned N_READ         = 2,
  parameter bit          BYPASS         = 1'b1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                ClearReq,
  output logic                                Busy,
  input  logic [N_READ-1:0]                   ReadEnable,
  input  logic [N_READ-1:0][ADDR_WIDTH-1:0]   ReadAddr,
  output logic [N_READ-1:0][DATA_WIDTH-1:0]   ReadData,
  input  logic                                WriteEnable,
  input  logic [ADDR_WIDTH-1:0]               WriteAddr,
  input  logic [DATA_WIDTH/8-1:0]             WriteBe,
  input  logic [DATA_WIDTH-1:0]               WriteData
);

  localparam int unsigned            N_WORDS  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]  LAST_IDX = ADDR_WIDTH'(N_WORDS - 1);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("ff_register_file_nr_1w_be: DATA_WIDTH must be a multiple of 8");
  end
  if (DATA_WIDTH > RF_MAX_DW) begin : g_data_width_too_wide
    $error("ff_register_file_nr_1w_be: DATA_WIDTH exceeds be_merge width");
  end
  if (N_READ < 1) begin : g_bad_n_read
    $error("ff_register_file_nr_1w_be: N_READ must be at least 1");
  end

  rf_clr_state_e                     state_q;
  rf_clr_state_e                     state_d;
  logic [ADDR_WIDTH-1:0]             clr_idx_q;
  logic [ADDR_WIDTH-1:0]             clr_idx_d;
  logic                              busy_q;
  logic                              wr_accept;
  logic [DATA_WIDTH-1:0]             wr_merged;
  logic [N_WORDS-1:0][DATA_WIDTH-1:0] mem_q;

  assign busy_q    = (state_q == CLEAR);
  assign Busy      = busy_q;
  assign wr_accept = WriteEnable && !busy_q;
  assign wr_merged = DATA_WIDTH'(be_merge(RF_MAX_DW'(mem_q[WriteAddr]),
                                          RF_MAX_DW'(WriteData),
                                          RF_MAX_BE'(WriteBe)));

  // Clear engine next state: walk every index once, then fall back to IDLE.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      IDLE: begin
        if (ClearReq) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        clr_idx_d = clr_idx_q + ADDR_WIDTH'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  // Clear engine state register; reset either restarts or aborts a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Storage array: clear engine has priority, user writes only when idle.
  // Held during reset so reset alone never disturbs contents.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (busy_q) begin
        mem_q[clr_idx_q] <= '0;
      end else if (wr_accept) begin
        mem_q[WriteAddr] <= wr_merged;
      end
    end
  end

  for (genvar p = 0; p < int'(N_READ); p++) begin : g_read_port
    ff_rf_read_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .N_WORDS    (N_WORDS),
      .BYPASS     (BYPASS)
    ) u_read_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .busy_i    (busy_q),
      .rd_en_i   (ReadEnable[p]),
      .rd_addr_i (ReadAddr[p]),
      .mem_i     (mem_q),
      .wr_en_i   (wr_accept),
      .wr_addr_i (WriteAddr),
      .wr_be_i   (WriteBe),
      .wr_data_i (WriteData),
      .rd_data_o (ReadData[p])
    );
  end

endmodule
